// File: rtl/vga_frame_scan_if.sv
// Host-side bus of vga_frame_scan: shadow-bank writes, the commit handshake
// and the active ball bank that feeds the renderers.
interface vga_frame_scan_if;
  logic        shadow_wr;
  logic [2:0]  shadow_sel;
  logic [31:0] shadow_data;
  logic        commit_req;
  logic        commit_ack;
  logic        commit_pending;
  logic [31:0] radius;
  logic [31:0] posX;
  logic [31:0] posY;
  logic [31:0] posZ;
  logic [31:0] relative_shift_z;

  modport master (
    output shadow_wr, shadow_sel, shadow_data, commit_req,
    input  commit_ack, commit_pending,
    input  radius, posX, posY, posZ, relative_shift_z
  );

  modport slave (
    input  shadow_wr, shadow_sel, shadow_data, commit_req,
    output commit_ack, commit_pending,
    output radius, posX, posY, posZ, relative_shift_z
  );
endinterface

// File: rtl/vga_frame_scan.sv
// VGA raster scan generator with a double-buffered ball parameter bank.
// Host writes land in a shadow bank; a requested commit copies it to the active bank at vblank entry.
module vga_frame_scan #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic            Clk,
  input  logic            Reset,
  vga_frame_scan_if.slave host,
  output logic [31:0]     DrawX,
  output logic [31:0]     DrawY,
  output logic            VGA_CLK,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            VGA_BLANK_N,
  output logic            VGA_SYNC_N,
  output logic            frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int          NBANK   = 5;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEGIN   = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_VIS_LAST = VW'(V_VISIBLE - 1);
  localparam logic [VW-1:0] VS_BEGIN   = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } commit_state_e;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          vclk_q, vclk_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic          frame_start_q;
  logic          ack_q;
  logic          pe_s;
  logic          vblank_entry_s;
  logic          frame_wrap_s;
  logic          commit_s;
  commit_state_e state_q, state_d;
  logic [31:0]   shadow_q [NBANK];
  logic [31:0]   active_q [NBANK];

  // Pixel divider, raster counters and sync/blank decode of the next count
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    pe_s  = (div_q == DIV_LAST);
    if (pe_s) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end else begin
      div_d = div_q + DW'(1);
    end
    vclk_d         = (div_d < DIV_HALF);
    hs_d           = !((h_d >= HS_BEGIN) && (h_d < HS_END));
    vs_d           = !((v_d >= VS_BEGIN) && (v_d < VS_END));
    blank_n_d      = (h_d < H_VIS) && (v_d < V_VIS);
    vblank_entry_s = pe_s && (h_q == H_LAST) && (v_q == V_VIS_LAST);
    frame_wrap_s   = pe_s && (h_q == H_LAST) && (v_q == V_LAST);
  end

  // Commit FSM: a request made on the vblank-entry cycle itself commits immediately
  always_comb begin
    state_d  = state_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (host.commit_req && vblank_entry_s) begin
          commit_s = 1'b1;
          state_d  = ST_IDLE;
        end else if (host.commit_req) begin
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (vblank_entry_s) begin
          commit_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; the commit copies shadow_q before any same-cycle write lands
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      vclk_q        <= 1'b1;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
      ack_q         <= 1'b0;
      state_q       <= ST_IDLE;
      for (int i = 0; i < NBANK; i++) begin
        shadow_q[i] <= 32'd0;
        active_q[i] <= 32'd0;
      end
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      vclk_q        <= vclk_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_wrap_s;
      ack_q         <= commit_s;
      state_q       <= state_d;
      if (host.shadow_wr) begin
        case (host.shadow_sel)
          3'd0:    shadow_q[0] <= host.shadow_data;
          3'd1:    shadow_q[1] <= host.shadow_data;
          3'd2:    shadow_q[2] <= host.shadow_data;
          3'd3:    shadow_q[3] <= host.shadow_data;
          3'd4:    shadow_q[4] <= host.shadow_data;
          default: ;
        endcase
      end
      if (commit_s) begin
        for (int i = 0; i < NBANK; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign DrawX       = {{(32 - HW){1'b0}}, h_q};
  assign DrawY       = {{(32 - VW){1'b0}}, v_q};
  assign VGA_CLK     = vclk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_start = frame_start_q;

  assign host.commit_ack       = ack_q;
  assign host.commit_pending   = (state_q == ST_PEND);
  assign host.radius           = active_q[0];
  assign host.posX             = active_q[1];
  assign host.posY             = active_q[2];
  assign host.posZ             = active_q[3];
  assign host.relative_shift_z = active_q[4];

endmodule

// File: tb/tb_vga_frame_scan.sv
// Directed bench for vga_frame_scan: a full-size instance checks line timing,
// a reduced-geometry instance (16x12 raster) exercises frame timing and the commit path.
module tb_vga_frame_scan;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;

  logic [31:0] f_x, f_y, s_x, s_y;
  logic        f_vclk, f_hs, f_vs, f_blank, f_sync, f_fs;
  logic        s_vclk, s_hs, s_vs, s_blank, s_sync, s_fs;

  vga_frame_scan_if hif_f ();
  vga_frame_scan_if hif_s ();

  vga_frame_scan u_full (
    .Clk(Clk), .Reset(Reset), .host(hif_f.slave),
    .DrawX(f_x), .DrawY(f_y), .VGA_CLK(f_vclk), .VGA_HS(f_hs), .VGA_VS(f_vs),
    .VGA_BLANK_N(f_blank), .VGA_SYNC_N(f_sync), .frame_start(f_fs)
  );

  // Small raster: H 8/2/3/3 (total 16, HS low x in [10,13)), V 6/2/2/2 (total 12, VS low y in [8,10))
  vga_frame_scan #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) u_small (
    .Clk(Clk), .Reset(Reset), .host(hif_s.slave),
    .DrawX(s_x), .DrawY(s_y), .VGA_CLK(s_vclk), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK_N(s_blank), .VGA_SYNC_N(s_sync), .frame_start(s_fs)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [159:0] bank_s();
    return {hif_s.radius, hif_s.posX, hif_s.posY, hif_s.posZ, hif_s.relative_shift_z};
  endfunction

  task automatic write_shadow(input logic [2:0] sel, input logic [31:0] data);
    hif_s.shadow_wr   = 1'b1;
    hif_s.shadow_sel  = sel;
    hif_s.shadow_data = data;
    tick();
    hif_s.shadow_wr   = 1'b0;
  endtask

  task automatic commit_pulse();
    hif_s.commit_req = 1'b1;
    tick();
    hif_s.commit_req = 1'b0;
  endtask

  // Advance the small DUT to (x,y), counting acks and active-bank changes on the way
  task automatic wait_pos(input string tag, input int x, input int y, output int acks, output int chg);
    logic [159:0] prev;
    acks = 0;
    chg  = 0;
    prev = bank_s();
    for (int i = 0; i < 1000; i++) begin
      if (s_x == x && s_y == y) break;
      tick();
      if (hif_s.commit_ack) acks++;
      if (bank_s() != prev) chg++;
      prev = bank_s();
    end
    check_val(tag, {s_y[15:0], s_x[15:0]}, {y[15:0], x[15:0]});
  endtask

  initial begin
    int ex, ey, bad_xy, bad_clk, bad_blank, hs_low, first_hs, fs_cnt;
    int flen, vs_low, bl_high, bad_sync, fs_in;
    int acks, chg, a2, c2;

    n_cmp = 0;
    n_err = 0;
    Reset = 1'b0;
    hif_f.shadow_wr = 1'b0; hif_f.shadow_sel = 3'd0; hif_f.shadow_data = 32'd0; hif_f.commit_req = 1'b0;
    hif_s.shadow_wr = 1'b0; hif_s.shadow_sel = 3'd0; hif_s.shadow_data = 32'd0; hif_s.commit_req = 1'b0;
    repeat (3) tick();

    // Reset state
    check_val("rst_drawx", f_x, 32'd0);
    check_val("rst_drawy", f_y, 32'd0);
    check_val("rst_vgaclk", f_vclk, 1'b1);
    check_val("rst_syncs", {f_hs, f_vs, f_blank, f_sync, f_fs}, 5'b11100);
    check_val("rst_commit", {hif_s.commit_ack, hif_s.commit_pending}, 2'b00);
    check_val("rst_bank", bank_s(), 160'd0);

    // Test 1: one full line plus the wrap on the full-size instance
    Reset = 1'b1;
    bad_xy = 0; bad_clk = 0; bad_blank = 0; hs_low = 0; first_hs = -1; fs_cnt = 0;
    for (int k = 1; k <= 1600; k++) begin
      tick();
      ex = (k / 2) % 800;
      ey = k / 1600;
      if (f_x != ex || f_y != ey) bad_xy++;
      if (f_vclk != ((k % 2) == 0)) bad_clk++;
      if (f_blank != (ex < 640)) bad_blank++;
      if (!f_hs) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(f_x);
      end
      if (f_fs) fs_cnt++;
    end
    check_val("line_xy_seq", bad_xy, 0);
    check_val("line_end_y", f_y, 32'd1);
    check_val("vgaclk_phase", bad_clk, 0);
    check_val("line_blank", bad_blank, 0);
    check_val("hs_low_clks", hs_low, 192);
    check_val("hs_first_x", first_hs, 656);
    check_val("no_fs_in_line", fs_cnt, 0);

    // Test 2: one full small frame, 16*12*2 = 384 Clk
    for (int i = 0; i < 1000; i++) begin
      if (s_fs) break;
      tick();
    end
    check_val("fs_seen", s_fs, 1'b1);
    check_val("fs_at_origin", {s_y[15:0], s_x[15:0]}, 32'd0);
    flen = 0; vs_low = 0; bl_high = 0; bad_sync = 0; fs_in = 0;
    do begin
      if (!s_vs) vs_low++;
      if (s_blank) bl_high++;
      if (s_fs) fs_in++;
      if (s_hs != !(s_x >= 10 && s_x < 13)) bad_sync++;
      if (s_vs != !(s_y >= 8 && s_y < 10)) bad_sync++;
      if (s_blank != (s_x < 8 && s_y < 6)) bad_sync++;
      tick();
      flen++;
    end while (!s_fs && flen < 1000);
    check_val("frame_len", flen, 384);
    check_val("vs_low_clks", vs_low, 64);
    check_val("blank_high_clks", bl_high, 96);
    check_val("sync_decode", bad_sync, 0);
    check_val("fs_one_clk", fs_in, 1);

    // Test 3: commit requested mid-frame lands exactly at (0,6)
    write_shadow(3'd1, 32'h3F800000);
    write_shadow(3'd0, 32'h3E4CCCCD);
    wait_pos("t3_req_pos", 0, 2, acks, chg);
    commit_pulse();
    check_val("t3_pending", hif_s.commit_pending, 1'b1);
    wait_pos("t3_vblank", 0, 6, acks, chg);
    check_val("t3_ack_count", acks, 1);
    check_val("t3_bank_changes", chg, 1);
    check_val("t3_ack_now", hif_s.commit_ack, 1'b1);
    check_val("t3_posx", hif_s.posX, 32'h3F800000);
    check_val("t3_radius", hif_s.radius, 32'h3E4CCCCD);
    check_val("t3_pend_clear", hif_s.commit_pending, 1'b0);
    tick();
    check_val("t3_ack_pulse", hif_s.commit_ack, 1'b0);

    // Test 4: request and posY write on the vblank-entry cycle itself
    for (int i = 0; i < 1000; i++) begin
      if (s_x == 15 && s_y == 5 && !s_vclk) break;
      tick();
    end
    check_val("t4_entry_pos", {s_y[15:0], s_x[15:0]}, {16'd5, 16'd15});
    hif_s.commit_req  = 1'b1;
    hif_s.shadow_wr   = 1'b1;
    hif_s.shadow_sel  = 3'd2;
    hif_s.shadow_data = 32'h40000000;
    tick();
    hif_s.commit_req = 1'b0;
    hif_s.shadow_wr  = 1'b0;
    check_val("t4_ack", hif_s.commit_ack, 1'b1);
    check_val("t4_old_posy", hif_s.posY, 32'd0);
    check_val("t4_posx_kept", hif_s.posX, 32'h3F800000);
    check_val("t4_no_pending", hif_s.commit_pending, 1'b0);
    commit_pulse();
    wait_pos("t4_wrap", 0, 0, acks, chg);
    wait_pos("t4_vblank2", 0, 6, a2, c2);
    check_val("t4_ack2", acks + a2, 1);
    check_val("t4_new_posy", hif_s.posY, 32'h40000000);

    // Test 5: reset mid-frame with a commit pending
    commit_pulse();
    wait_pos("t5_pos", 5, 3, acks, chg);
    check_val("t5_pending_before", hif_s.commit_pending, 1'b1);
    check_val("t5_no_early_ack", acks, 0);
    Reset = 1'b0;
    tick();
    check_val("t5_origin", {s_y[15:0], s_x[15:0]}, 32'd0);
    check_val("t5_full_origin", {f_y[15:0], f_x[15:0]}, 32'd0);
    check_val("t5_pending_clear", hif_s.commit_pending, 1'b0);
    check_val("t5_bank_zero", bank_s(), 160'd0);
    Reset = 1'b1;
    wait_pos("t5_vblank", 0, 6, acks, chg);
    check_val("t5_no_ack", acks, 0);
    check_val("t5_bank_still", chg, 0);

    // Test 6: three requests in one frame give one commit; selects 5-7 write nothing
    write_shadow(3'd3, 32'h12345678);
    write_shadow(3'd4, 32'hFFFFFFF6);
    write_shadow(3'd5, 32'hDEADBEEF);
    write_shadow(3'd7, 32'hCAFEF00D);
    wait_pos("t6_y1", 0, 1, acks, chg);
    commit_pulse();
    check_val("t6_pending", hif_s.commit_pending, 1'b1);
    wait_pos("t6_y2", 0, 2, acks, chg);
    commit_pulse();
    wait_pos("t6_y4", 0, 4, a2, c2);
    commit_pulse();
    check_val("t6_pre_acks", acks + a2, 0);
    wait_pos("t6_vblank", 0, 6, acks, chg);
    check_val("t6_one_ack", acks, 1);
    check_val("t6_bank", bank_s(), {32'd0, 32'd0, 32'd0, 32'h12345678, 32'hFFFFFFF6});
    wait_pos("t6_wrap", 0, 0, acks, chg);
    wait_pos("t6_vblank2", 0, 6, a2, c2);
    check_val("t6_no_second_ack", acks + a2, 0);
    check_val("t6_idle", hif_s.commit_pending, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
